act_rr_sched: RTL and testbench
===============================

// Module: act_rr_sched
// PURPOSE
//  Shares one Relu activation unit (fixed-latency, no backpressure) among CH_N requester streams.
//  - Round-robin issue of input beats; channel tag carried through a delay line matched to the unit latency.
//  - Results are steered into per-channel output FIFOs.
//  - Per-channel credits guarantee a FIFO slot exists before issue, so the unstallable pipeline never overflows.
// PARAMETERS
//  CH_N             4    number of requester channels (2..8)
//  DATA_W           32   act data width (= act_cal_width*2 of the activation unit)
//  ACT_LAT          2    activation unit latency, act_in_vld -> act_out_vld (>=1)
//  FIFO_DEPTH       4    per-channel output FIFO depth (power of 2, >=2)
//  SIM_DELAY        1    simulation delay on register updates
// PORTS
//  clk              in   1              clock
//  rst_n            in   1              async active-low reset
//  s_data           in   CH_N*DATA_W    channel i input beat at [i*DATA_W +: DATA_W]
//  s_last           in   CH_N           last beat of a packet (used only with ACT_SCHED_PKT_LOCK_EN)
//  s_valid          in   CH_N           input valid per channel
//  s_ready          out  CH_N           input accepted (one-hot or zero)
//  act_in           out  DATA_W         to activation unit
//  act_in_vld       out  1              to activation unit
//  act_out          in   DATA_W         from activation unit
//  act_out_vld      in   1              from activation unit
//  m_data           out  CH_N*DATA_W    per-channel result (FIFO head)
//  m_valid          out  CH_N           per-channel FIFO not empty
//  m_ready          in   CH_N           per-channel pop
//  sync_err         out  1              sticky: act_out_vld disagrees with tag pipe valid
// BEHAVIOUR
//  - Reset: s_ready=0, act_in_vld=0, m_valid=0, sync_err=0, rr_ptr=0, credits=FIFO_DEPTH, tag pipe empty.
//  - Eligible(i) = s_valid[i] & (credit[i]!=0).
//  - Grant: first eligible channel scanning rr_ptr, rr_ptr+1, ... (mod CH_N). Combinational, same cycle.
//  - On grant g:
//    - s_ready[g]=1, act_in=s_data[g], act_in_vld=1, credit[g]-=1.
//    - rr_ptr <= (g+1) mod CH_N.
//  - No eligible channel: act_in_vld=0, rr_ptr holds.
//  - Tag pipe: ACT_LAT-stage shift of {vld, ch_id}; stage 0 loaded with {act_in_vld, g} every cycle.
//  - On pipe output:
//    - act_out_vld & tag_vld: push act_out into FIFO[tag_id].
//    - act_out_vld != tag_vld: sync_err<=1 (sticky until reset); no push.
//  - Pop: m_valid[i]&m_ready[i] pops FIFO[i] and credit[i]+=1.
//  - Issue and pop on the same channel in the same cycle: credit unchanged.
//  - Credit invariant: credit[i] + in-flight[i] + occupancy[i] == FIFO_DEPTH.
//    - A push into a full FIFO is unreachable; it is asserted in simulation.
//  - Throughput: one beat/cycle total while any channel is eligible. Latency s->m_valid = ACT_LAT+1 cycles.
//  - Full credit-starved (all credits 0): no issue, s_ready=0, in-flight beats still drain.
//  - Reset mid-operation: in-flight tags, FIFO contents and credits discarded immediately.
//    - The activation unit is reset by the same rst_n.
//  - Wrap-around: rr_ptr, FIFO pointers wrap modulo CH_N / FIFO_DEPTH.
// CONFIGURATION
//  ACT_SCHED_PKT_LOCK_EN defined:
//  - Once channel g is granted with s_last[g]=0, grant is locked to g until a beat with s_last[g]=1 issues.
//  - While locked, no other channel issues even if g stalls (not eligible).
//  - rr_ptr advances only on the last beat.
//  ACT_SCHED_PKT_LOCK_EN undefined:
//  - s_last is ignored; arbitration is per beat.
// STRUCTURE
//  - Shared header act_sched_defs.vh: CH_ID_W = clog2(CH_N) function/macro, credit width = clog2(FIFO_DEPTH+1).
//  - Sub-module act_sched_fifo: sync FIFO, DATA_W x FIFO_DEPTH, one instance per channel (generate).
//  - Round-robin arbiter and tag pipe stay in top.
// TESTING (bench models the activation unit as an ACT_LAT delay of act_in)
//  1. Single channel 0, 8 beats, m_ready=1: 8 results in order, first m_valid 3 cycles after first s_ready.
//  2. All 4 channels valid continuously, m_ready=1: grants 0,1,2,3,0,...; act_in_vld=1 every cycle.
//  3. Channel 1 with m_ready[1]=0: exactly FIFO_DEPTH=4 beats accepted, then s_ready[1]=0.
//     - Other channels keep flowing.
//     - Raising m_ready[1] resumes issue one cycle after the first pop.
//  4. Same-cycle issue and pop on channel 2 at credit 1: credit stays 1 and issue continues.
//  5. Inject act_out_vld with an empty tag pipe: sync_err=1 and stays 1; no FIFO push.
//  6. rst_n pulse with 2 beats in flight: all m_valid=0 and credits=4 after release.
//     - With ACT_SCHED_PKT_LOCK_EN: a 3-beat packet on ch0 is not interleaved with ch1.

Source files
------------

// File: rtl/act_rr_sched_pkg.sv
// rtl/act_rr_sched_pkg.sv - shared widths, helpers and lock states for act_rr_sched (ACT_SCHED_PKT_LOCK_EN)
package act_rr_sched_pkg;

  // Packet-lock grant state; only used when ACT_SCHED_PKT_LOCK_EN is defined.
  typedef enum logic {
    SCHED_FREE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } sched_st_e;

  // Width of a channel id; a single channel still needs one bit.
  function automatic int ch_id_w(input int ch_n);
    return (ch_n > 1) ? $clog2(ch_n) : 1;
  endfunction

  // Width of a credit counter that must hold 0..depth inclusive.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/act_sched_fifo.sv
// rtl/act_sched_fifo.sv - per-channel result FIFO for act_rr_sched
module act_sched_fifo
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW1   = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              full;
  logic              pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign m_tvalid = (wr_ptr != rd_ptr);
  assign pop      = m_tvalid & m_tready;
  assign m_tdata  = mem[rd_ptr[PTR_W-1:0]];

  // Storage write; contents need no reset since valid comes from the pointers.
  always_ff @(posedge clk) begin
    if (s_tvalid && !full) begin
      mem[wr_ptr[PTR_W-1:0]] <= s_tdata;
    end
  end

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (s_tvalid && !full) wr_ptr <= wr_ptr + PW1'(1);
      if (pop)               rd_ptr <= rd_ptr + PW1'(1);
    end
  end

  // Credits upstream make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(s_tvalid && full));

endmodule

// File: rtl/act_rr_sched.sv
// rtl/act_rr_sched.sv - round-robin sharing of one activation unit among CH_N streams (ACT_SCHED_PKT_LOCK_EN: packet lock)
module act_rr_sched
  import act_rr_sched_pkg::*;
#(
  parameter int CH_N       = 4,
  parameter int DATA_W     = 32,
  parameter int ACT_LAT    = 2,
  parameter int FIFO_DEPTH = 4
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_N*DATA_W-1:0] s_data,
  input  logic [CH_N-1:0]        s_last,
  input  logic [CH_N-1:0]        s_valid,
  output logic [CH_N-1:0]        s_ready,
  output logic [DATA_W-1:0]      act_in,
  output logic                   act_in_vld,
  input  logic [DATA_W-1:0]      act_out,
  input  logic                   act_out_vld,
  output logic [CH_N*DATA_W-1:0] m_data,
  output logic [CH_N-1:0]        m_valid,
  input  logic [CH_N-1:0]        m_ready,
  output logic                   sync_err
);

  localparam int ID_W   = ch_id_w(CH_N);
  localparam int SUM_W  = ID_W + 1;
  localparam int CRED_W = cred_w(FIFO_DEPTH);

  logic [ID_W-1:0]   rr_ptr;
  logic              rr_vld;
  logic [ID_W-1:0]   rr_id;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic              rr_adv;
  logic [CRED_W-1:0] credit [CH_N];
  logic [CH_N-1:0]   eligible;
  logic [CH_N-1:0]   pop;
  logic [CH_N-1:0]   push;
  logic [2*CH_N-1:0] rot;
  logic [SUM_W-1:0]  sum;
  logic              tag_vld [ACT_LAT];
  logic [ID_W-1:0]   tag_id  [ACT_LAT];

  // A channel may issue only while it owns a free slot in its output FIFO.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < CH_N; i++) begin
      eligible[i] = rst_n & s_valid[i] & (credit[i] != '0);
    end
  end

  // Round-robin scan: rotate eligibility so rr_ptr lands on bit 0, take the lowest set bit.
  always_comb begin
    rot    = {eligible, eligible} >> rr_ptr;
    rr_vld = 1'b0;
    sum    = '0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rr_vld = 1'b1;
        sum    = {1'b0, rr_ptr} + SUM_W'(k);
      end
    end
    rr_id = (sum >= SUM_W'(CH_N)) ? ID_W'(sum - SUM_W'(CH_N)) : ID_W'(sum);
  end

`ifdef ACT_SCHED_PKT_LOCK_EN
  sched_st_e       lock_st;
  sched_st_e       lock_st_nxt;
  logic [ID_W-1:0] lock_ch;

  // Lock state register; remembers the channel whose packet is still open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_st <= SCHED_FREE;
      lock_ch <= '0;
    end else begin
      lock_st <= lock_st_nxt;
      if (grant_vld && lock_st_nxt == SCHED_LOCKED) lock_ch <= grant_id;
    end
  end

  // While locked only the owner may issue; a last beat releases the lock.
  always_comb begin
    lock_st_nxt = lock_st;
    grant_vld   = rr_vld;
    grant_id    = rr_id;
    if (lock_st == SCHED_LOCKED) begin
      grant_vld = eligible[lock_ch];
      grant_id  = lock_ch;
    end
    if (grant_vld) lock_st_nxt = s_last[grant_id] ? SCHED_FREE : SCHED_LOCKED;
  end

  assign rr_adv = grant_vld & s_last[grant_id];
`else
  logic unused_last;

  // Per-beat arbitration: the scan result is the grant.
  always_comb begin
    grant_vld = rr_vld;
    grant_id  = rr_id;
  end

  assign unused_last = ^s_last;
  assign rr_adv      = grant_vld;
`endif

  // Grant fans out to the requester handshake and the activation unit input.
  always_comb begin
    s_ready = '0;
    act_in  = '0;
    for (int i = 0; i < CH_N; i++) begin
      if (grant_id == ID_W'(i)) begin
        s_ready[i] = grant_vld;
        act_in     = s_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign act_in_vld = grant_vld;

  // Pointer moves just past the channel that issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (rr_adv) begin
      rr_ptr <= (grant_id == ID_W'(CH_N - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Tag delay line matches the activation unit latency so results find their owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ACT_LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
    end else begin
      tag_vld[0] <= grant_vld;
      tag_id[0]  <= grant_id;
      for (int k = 1; k < ACT_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // Results are steered only when the unit and the tag line agree.
  always_comb begin
    push = '0;
    for (int i = 0; i < CH_N; i++) begin
      push[i] = act_out_vld & tag_vld[ACT_LAT-1] & (tag_id[ACT_LAT-1] == ID_W'(i));
    end
  end

  // Any disagreement between unit output and tag line latches an error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (act_out_vld != tag_vld[ACT_LAT-1]) begin
      sync_err <= 1'b1;
    end
  end

  assign pop = m_valid & m_ready;

  // Credit spent on issue, returned on pop; both at once leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_N; i++) credit[i] <= CRED_W'(FIFO_DEPTH);
    end else begin
      for (int i = 0; i < CH_N; i++) begin
        case ({s_ready[i], pop[i]})
          2'b10:   credit[i] <= credit[i] - CRED_W'(1);
          2'b01:   credit[i] <= credit[i] + CRED_W'(1);
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < CH_N; gi++) begin : g_fifo
    act_sched_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_tdata  (act_out),
      .s_tvalid (push[gi]),
      .m_tdata  (m_data[gi*DATA_W +: DATA_W]),
      .m_tvalid (m_valid[gi]),
      .m_tready (m_ready[gi])
    );
  end

endmodule

// File: tb/tb_act_rr_sched.sv
// tb/tb_act_rr_sched.sv - randomized self-checking bench for act_rr_sched against a queue-based model
module tb_act_rr_sched;

  localparam int CH_N       = 4;
  localparam int DATA_W     = 32;
  localparam int ACT_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
`ifdef ACT_SCHED_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [CH_N*DATA_W-1:0] s_data;
  logic [CH_N-1:0]        s_last;
  logic [CH_N-1:0]        s_valid;
  logic [CH_N-1:0]        s_ready;
  logic [DATA_W-1:0]      act_in;
  logic                   act_in_vld;
  logic [DATA_W-1:0]      act_out;
  logic                   act_out_vld;
  logic [CH_N*DATA_W-1:0] m_data;
  logic [CH_N-1:0]        m_valid;
  logic [CH_N-1:0]        m_ready;
  logic                   sync_err;
  logic                   inject;

  logic [DATA_W-1:0] dly_d [ACT_LAT];
  logic              dly_v [ACT_LAT];

  always #5 clk = ~clk;

  act_rr_sched #(
    .CH_N       (CH_N),
    .DATA_W     (DATA_W),
    .ACT_LAT    (ACT_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .act_in      (act_in),
    .act_in_vld  (act_in_vld),
    .act_out     (act_out),
    .act_out_vld (act_out_vld),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .sync_err    (sync_err)
  );

  // Activation unit stand-in: pure ACT_LAT delay, reset with the scheduler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ACT_LAT; k++) begin
        dly_v[k] <= 1'b0;
        dly_d[k] <= '0;
      end
    end else begin
      dly_v[0] <= act_in_vld;
      dly_d[0] <= act_in;
      for (int k = 1; k < ACT_LAT; k++) begin
        dly_v[k] <= dly_v[k-1];
        dly_d[k] <= dly_d[k-1];
      end
    end
  end

  assign act_out     = dly_d[ACT_LAT-1];
  assign act_out_vld = dly_v[ACT_LAT-1] | inject;

  typedef struct {
    int                due;
    int                ch;
    logic [DATA_W-1:0] d;
  } flight_t;

  flight_t           flight [$];
  logic [DATA_W-1:0] fq [CH_N][$];
  int  ptr, cyc, lock_on, lock_ch;
  bit  exp_sync;
  int  n_cmp, n_bad;
  int  acc [CH_N];
  int  rdy_obs [CH_N];
  int  pop_obs [CH_N];
  int  vld_obs;
  int  g0_seen, mv0_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int credit_of(input int ch);
    int n;
    n = FIFO_DEPTH - fq[ch].size();
    foreach (flight[j]) if (flight[j].ch == ch) n--;
    return n;
  endfunction

  task automatic clr_obs();
    for (int i = 0; i < CH_N; i++) begin
      rdy_obs[i] = 0;
      pop_obs[i] = 0;
    end
    vld_obs  = 0;
    g0_seen  = -1;
    mv0_seen = -1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < CH_N; i++) s_data[i*DATA_W +: DATA_W] = $urandom;
  endtask

  // One cycle: compare DUT against the model, then advance the model across the clock edge.
  task automatic step();
    int               g;
    int               c;
    bit               due_hit;
    logic [CH_N-1:0]  exp_rdy;
    logic [CH_N-1:0]  exp_mv;
    flight_t          f;
    #1;
    g = -1;
    if (!rst_n) begin
      flight.delete();
      for (int i = 0; i < CH_N; i++) fq[i].delete();
      ptr      = 0;
      lock_on  = 0;
      exp_sync = 1'b0;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_act_in_vld", 64'(act_in_vld), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_sync_err", 64'(sync_err), 64'd0);
    end else begin
      if (LOCK && lock_on != 0) begin
        if (s_valid[lock_ch] && credit_of(lock_ch) > 0) g = lock_ch;
      end else begin
        for (int k = 0; k < CH_N; k++) begin
          c = (ptr + k) % CH_N;
          if (g < 0 && s_valid[c] && credit_of(c) > 0) g = c;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      for (int i = 0; i < CH_N; i++) exp_mv[i] = (fq[i].size() > 0);
      chk("s_ready", 64'(s_ready), 64'(exp_rdy));
      chk("act_in_vld", 64'(act_in_vld), 64'(g >= 0));
      if (g >= 0) chk("act_in", 64'(act_in), 64'(s_data[g*DATA_W +: DATA_W]));
      chk("m_valid", 64'(m_valid), 64'(exp_mv));
      for (int i = 0; i < CH_N; i++) begin
        if (exp_mv[i]) chk($sformatf("m_data%0d", i), 64'(m_data[i*DATA_W +: DATA_W]), 64'(fq[i][0]));
      end
      chk("sync_err", 64'(sync_err), 64'(exp_sync));

      for (int i = 0; i < CH_N; i++) begin
        if (s_ready[i]) rdy_obs[i]++;
        if (m_valid[i] && m_ready[i]) pop_obs[i]++;
      end
      if (act_in_vld) vld_obs++;
      if (g == 0 && g0_seen < 0) g0_seen = cyc;
      if (m_valid[0] && mv0_seen < 0) mv0_seen = cyc;

      for (int i = 0; i < CH_N; i++) begin
        if (exp_mv[i] && m_ready[i]) void'(fq[i].pop_front());
      end
      due_hit = (flight.size() > 0) && (flight[0].due == cyc);
      if (due_hit) begin
        fq[flight[0].ch].push_back(flight[0].d);
        void'(flight.pop_front());
      end
      if (inject && !due_hit) exp_sync = 1'b1;
      if (g >= 0) begin
        f.due = cyc + ACT_LAT;
        f.ch  = g;
        f.d   = s_data[g*DATA_W +: DATA_W];
        flight.push_back(f);
        acc[g]++;
        if (LOCK) begin
          if (s_last[g]) begin
            lock_on = 0;
            ptr     = (g + 1) % CH_N;
          end else begin
            lock_on = 1;
            lock_ch = g;
          end
        end else begin
          ptr = (g + 1) % CH_N;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [CH_N-1:0] vld, input logic [CH_N-1:0] rdy);
    s_valid = vld;
    m_ready = rdy;
    for (int k = 0; k < n; k++) begin
      rand_data();
      step();
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; ptr = 0; lock_on = 0; lock_ch = 0; exp_sync = 1'b0;
    for (int i = 0; i < CH_N; i++) acc[i] = 0;
    clr_obs();
    rst_n = 1'b0; inject = 1'b0; s_valid = '0; s_last = '1; s_data = '0; m_ready = '1;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // Single channel stream: order, count and first-result latency.
    clr_obs();
    run(8, 4'b0001, 4'b1111);
    run(8, 4'b0000, 4'b1111);
    chk("t1_results", 64'(pop_obs[0]), 64'd8);
    chk("t1_latency", 64'(mv0_seen - g0_seen), 64'(ACT_LAT + 1));

    // All channels busy: one issue every cycle.
    clr_obs();
    run(16, 4'b1111, 4'b1111);
    chk("t2_issue_rate", 64'(vld_obs), 64'd16);
    run(8, 4'b0000, 4'b1111);

    // Channel 1 backpressured: exactly FIFO_DEPTH beats, others keep flowing.
    clr_obs();
    run(20, 4'b1111, 4'b1101);
    chk("t3_ch1_accepts", 64'(rdy_obs[1]), 64'(FIFO_DEPTH));
    chk("t3_ch0_flowing", 64'(rdy_obs[0] >= 5), 64'd1);
    run(10, 4'b1111, 4'b1111);
    run(8, 4'b0000, 4'b1111);

    // Channel 2 at credit 1 with a pop every cycle: issue never stops.
    run(3, 4'b0100, 4'b1011);
    run(5, 4'b0000, 4'b1011);
    clr_obs();
    run(8, 4'b0100, 4'b1111);
    chk("t4_ch2_accepts", 64'(rdy_obs[2]), 64'd8);
    run(8, 4'b0000, 4'b1111);

    // Spurious unit output with nothing in flight.
    run(4, 4'b0000, 4'b1111);
    inject = 1'b1;
    run(1, 4'b0000, 4'b1111);
    inject = 1'b0;
    run(4, 4'b0000, 4'b1111);
    chk("t5_sync_sticky", 64'(sync_err), 64'd1);

    // Reset with beats in flight, then confirm full credits by backpressuring ch0.
    run(2, 4'b0011, 4'b1111);
    s_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(4, 4'b0000, 4'b1111);
    clr_obs();
    run(8, 4'b0001, 4'b1110);
    chk("t6_credits", 64'(rdy_obs[0]), 64'(FIFO_DEPTH));
    run(8, 4'b0000, 4'b1111);

    // Three-beat packets on ch0 competing with single beats on ch1.
    s_valid = 4'b0011;
    m_ready = '1;
    for (int k = 0; k < 12; k++) begin
      rand_data();
      s_last = 4'b1110 | CH_N'(acc[0] % 3 == 2);
      step();
    end
    run(8, 4'b0000, 4'b1111);

    // Random traffic, backpressure and packet boundaries.
    for (int k = 0; k < 600; k++) begin
      rand_data();
      s_valid = CH_N'($urandom);
      m_ready = CH_N'($urandom) | CH_N'($urandom);
      s_last  = CH_N'($urandom) | CH_N'($urandom);
      step();
    end
    s_last = '1;
    run(12, 4'b0000, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
